// File: rtl/fifo_read_streamer.sv
// -----------------------------------------------------------------------------
// fifo_read_streamer
//
// Pulls words out of a standard-mode (registered-output, read latency 1) FIFO
// and presents them as a valid/ready stream through a small skid buffer.
// Each FIFO word carries the payload in bits [Width-2:0] and an end-of-packet
// marker in bit [Width-1].
//
// Handshake semantics (stream side): a word transfers on every rising edge
// where OutValid && OutReady are both high. Once OutValid is raised it stays
// high, and OutData/OutLast stay stable, until that transfer happens.
//
// Read-side flow control is credit based: a read is only issued when the
// buffer has room for it and every read still in flight. Because of this, the
// read enable never depends on OutReady, which keeps the FIFO read path free
// of the downstream consumer's timing.
//
// Ports
//   Clk            in   clock, everything on the rising edge
//   Reset_n        in   synchronous active-low reset
//   FifoDout       in   FIFO read data (Width bits, MSB = end-of-packet)
//   FifoEmpty      in   FIFO empty flag
//   FifoValid      in   FIFO read data valid, one cycle after FifoRdEn
//   FifoRdRstBusy  in   FIFO read side in reset, reads blocked while high
//   FifoRdEn       out  FIFO read enable
//   OutData        out  stream payload (Width-1 bits)
//   OutLast        out  stream end-of-packet
//   OutValid       out  stream valid
//   OutReady       in   stream ready
//   PktCount       out  completed packets, wraps modulo 2^CountWidth
//   Idle           out  buffer empty and no read in flight
//   ErrUnderflow   out  sticky: a read was issued but no data came back
//   ErrSpurious    out  sticky: data came back with no read in flight
// -----------------------------------------------------------------------------
module fifo_read_streamer #(
    parameter int Width      = 9,
    parameter int BufDepth   = 4,
    parameter int CountWidth = 16
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [Width-1:0]      FifoDout,
    input  logic                  FifoEmpty,
    input  logic                  FifoValid,
    input  logic                  FifoRdRstBusy,
    output logic                  FifoRdEn,
    output logic [Width-2:0]      OutData,
    output logic                  OutLast,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [CountWidth-1:0] PktCount,
    output logic                  Idle,
    output logic                  ErrUnderflow,
    output logic                  ErrSpurious
);

    localparam int PtrWidth = (BufDepth > 1) ? $clog2(BufDepth) : 1;
    localparam int OccWidth = PtrWidth + 1;
    localparam logic [OccWidth-1:0] Depth = OccWidth'(BufDepth);

    if (BufDepth < 2 || BufDepth > 16 || (BufDepth & (BufDepth - 1)) != 0) begin : g_bad_depth
        $error("fifo_read_streamer: BufDepth must be a power of two between 2 and 16");
    end

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [Width-1:0]      store [BufDepth];
    logic [PtrWidth-1:0]   wr_ptr;
    logic [PtrWidth-1:0]   rd_ptr;
    logic [OccWidth-1:0]   occ;
    logic                  in_flight;
    logic                  post_reset;
    logic [CountWidth-1:0] pkt_count;
    logic                  err_underflow;
    logic                  err_spurious;

    // -------------------------------------------------------------------------
    // Combinational control
    // -------------------------------------------------------------------------
    logic [OccWidth-1:0] committed;
    logic                rd_en;
    logic                push;
    logic                pop;
    logic [Width-1:0]    head;

    always_comb begin
        // Slots already spoken for: stored words plus the word still on its way.
        committed = occ + OccWidth'(in_flight);
        // Reset_n gating keeps the read enable low for the whole reset cycle;
        // everything else comes from registered state and the FIFO's own flags.
        rd_en = Reset_n && !FifoEmpty && !FifoRdRstBusy && (committed < Depth);
    end

    always_comb begin
        head = store[rd_ptr];
        push = in_flight && FifoValid;
        pop  = (occ != '0) && OutReady;
    end

    // -------------------------------------------------------------------------
    // Buffer storage (payload only, no reset needed)
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset_n && push) begin
            store[wr_ptr] <= FifoDout;
        end
    end

    // -------------------------------------------------------------------------
    // Pointers, occupancy, in-flight tracking, counters and error flags
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occ           <= '0;
            in_flight     <= 1'b0;
            post_reset    <= 1'b1;
            pkt_count     <= '0;
            err_underflow <= 1'b0;
            err_spurious  <= 1'b0;
        end else begin
            post_reset <= 1'b0;
            in_flight  <= rd_en;

            // Pointers wrap naturally because BufDepth is a power of two.
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase

            if (pop && head[Width-1]) begin
                pkt_count <= pkt_count + 1'b1;
            end

            if (in_flight && !FifoValid) begin
                err_underflow <= 1'b1;
            end

            // A return landing in the first cycle after reset belongs to a read
            // issued before reset; drop it quietly instead of flagging it.
            if (FifoValid && !in_flight && !post_reset) begin
                err_spurious <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        FifoRdEn     = rd_en;
        OutData      = head[Width-2:0];
        OutLast      = head[Width-1];
        OutValid     = (occ != '0);
        PktCount     = pkt_count;
        Idle         = (occ == '0) && !in_flight;
        ErrUnderflow = err_underflow;
        ErrSpurious  = err_spurious;
    end

    // The credit rule must make an overflowing push impossible.
    assert property (@(posedge Clk) disable iff (!Reset_n) push |-> (occ != Depth))
        else $error("fifo_read_streamer: push into a full buffer");

endmodule

// File: tb/tb_fifo_read_streamer.sv
// -----------------------------------------------------------------------------
// tb_fifo_read_streamer
//
// Directed bench for fifo_read_streamer with default parameters. A small
// standard-mode FIFO model feeds the DUT (read latency 1), a monitor records
// stream handshakes and read pulses, and one task per scenario checks results
// inline against hand-computed values.
// -----------------------------------------------------------------------------
module tb_fifo_read_streamer;

  localparam int W  = 9;
  localparam int CW = 16;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n = 1'b0;
  logic [W-1:0]  fifo_dout;
  logic          fifo_empty;
  logic          fifo_valid;
  logic          fifo_rd_rst_busy = 1'b0;
  logic          fifo_rd_en;
  logic [W-2:0]  out_data;
  logic          out_last;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] pkt_count;
  logic          idle;
  logic          err_underflow;
  logic          err_spurious;

  fifo_read_streamer #(.Width(W), .BufDepth(4), .CountWidth(CW)) dut (
    .Clk           (clk),
    .Reset_n       (reset_n),
    .FifoDout      (fifo_dout),
    .FifoEmpty     (fifo_empty),
    .FifoValid     (fifo_valid),
    .FifoRdRstBusy (fifo_rd_rst_busy),
    .FifoRdEn      (fifo_rd_en),
    .OutData       (out_data),
    .OutLast       (out_last),
    .OutValid      (out_valid),
    .OutReady      (out_ready),
    .PktCount      (pkt_count),
    .Idle          (idle),
    .ErrUnderflow  (err_underflow),
    .ErrSpurious   (err_spurious)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------------------------------------------------------------------
  // FIFO model: words in fifo_q; a read seen mid-cycle returns data one
  // cycle later. drop_next swallows the next read's data, spur_next injects
  // one valid with no read behind it.
  // ---------------------------------------------------------------------------
  logic [W-1:0] fifo_q[$];
  bit           drop_next = 1'b0;
  bit           spur_next = 1'b0;
  logic         model_rd;

  initial begin : fifo_model
    fifo_valid = 1'b0;
    fifo_dout  = '0;
    fifo_empty = 1'b1;
    forever begin
      @(negedge clk);
      model_rd = fifo_rd_en;
      @(posedge clk);
      #1;
      if (model_rd && drop_next) begin
        fifo_valid = 1'b0;
        drop_next  = 1'b0;
      end else if (model_rd && fifo_q.size() > 0) begin
        fifo_dout  = fifo_q.pop_front();
        fifo_valid = 1'b1;
      end else if (spur_next) begin
        fifo_dout  = '1;
        fifo_valid = 1'b1;
        spur_next  = 1'b0;
      end else begin
        fifo_valid = 1'b0;
      end
      fifo_empty = (fifo_q.size() == 0);
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: sampled mid-cycle, away from the active edge
  // ---------------------------------------------------------------------------
  logic [W-1:0] obs_q[$];
  int           hs_cyc_q[$];
  int           neg_cyc    = 0;
  int           rden_cnt   = 0;
  int           first_rden = -1;

  initial begin : monitor
    forever begin
      @(negedge clk);
      neg_cyc++;
      if (fifo_rd_en === 1'b1) begin
        if (first_rden < 0) first_rden = neg_cyc;
        rden_cnt++;
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        obs_q.push_back({out_last, out_data});
        hs_cyc_q.push_back(neg_cyc);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mon();
    obs_q.delete();
    hs_cyc_q.delete();
    rden_cnt   = 0;
    first_rden = -1;
  endtask

  task automatic wait_obs(input int n, input int budget, output bit timed_out);
    int k = 0;
    while (obs_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    timed_out = (obs_q.size() < n);
  endtask

  task automatic wait_occ(input int n, input int budget, output bit timed_out);
    int k = 0;
    while (int'(dut.occ) != n && k < budget) begin
      tick();
      k++;
    end
    timed_out = (int'(dut.occ) != n);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    bit to;
    reset_n   = 1'b0;
    out_ready = 1'b1;
    fifo_q.push_back(9'h1AA);
    repeat (3) tick();
    checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rden: got %b expected 0", fifo_rd_en); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle: got %b expected 1", idle); end
    checks++; if (pkt_count !== 16'd0) begin failures++; $display("FAIL reset_pkt: got %0d expected 0", pkt_count); end
    checks++; if ({err_underflow, err_spurious} !== 2'b00) begin failures++; $display("FAIL reset_err: got %b expected 00", {err_underflow, err_spurious}); end
    clear_mon();
    reset_n = 1'b1;
    #1;
    checks++; if (fifo_rd_en !== 1'b1) begin failures++; $display("FAIL first_rden_after_reset: got %b expected 1", fifo_rd_en); end
    wait_obs(1, 10, to);
    checks++; if (to) begin failures++; $display("FAIL reset_first_word_timeout: got %0d words expected 1", obs_q.size()); end
    if (!to) begin
      checks++; if (obs_q[0] !== 9'h1AA) begin failures++; $display("FAIL reset_first_word: got %h expected 1aa", obs_q[0]); end
      checks++; if (hs_cyc_q[0] - first_rden != 2) begin failures++; $display("FAIL first_latency: got %0d expected 2", hs_cyc_q[0] - first_rden); end
    end
    tick();
    checks++; if (pkt_count !== 16'd1) begin failures++; $display("FAIL reset_pkt_after: got %0d expected 1", pkt_count); end
  endtask

  task automatic test_single_packet();
    bit to;
    logic [W-1:0] exp_q[$];
    exp_q = '{9'h041, 9'h042, 9'h143};
    clear_mon();
    out_ready = 1'b1;
    foreach (exp_q[i]) fifo_q.push_back(exp_q[i]);
    wait_obs(3, 20, to);
    checks++; if (to) begin failures++; $display("FAIL single_timeout: got %0d words expected 3", obs_q.size()); end
    if (!to) begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL single_word%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
      end
      checks++; if (hs_cyc_q[2] - hs_cyc_q[0] != 2) begin failures++; $display("FAIL single_consecutive: got span %0d expected 2", hs_cyc_q[2] - hs_cyc_q[0]); end
    end
    checks++; if (pkt_count !== 16'd2) begin failures++; $display("FAIL single_pkt: got %0d expected 2", pkt_count); end
    repeat (2) tick();
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL single_idle: got %b expected 1", idle); end
  endtask

  task automatic test_backpressure();
    bit to;
    int held_bad = 0;
    logic [W-1:0] exp_q[$];
    for (int i = 0; i < 8; i++) exp_q.push_back((i == 7) ? 9'h117 : 9'(8'h10 + i));
    clear_mon();
    out_ready = 1'b0;
    foreach (exp_q[i]) fifo_q.push_back(exp_q[i]);
    for (int k = 0; k < 10; k++) begin
      tick();
      if (out_valid === 1'b1 && {out_last, out_data} !== 9'h010) held_bad++;
    end
    checks++; if (rden_cnt != 4) begin failures++; $display("FAIL bp_rden_pulses: got %0d expected 4", rden_cnt); end
    checks++; if (dut.occ !== 3'd4) begin failures++; $display("FAIL bp_occ: got %0d expected 4", dut.occ); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid: got %b expected 1", out_valid); end
    checks++; if ({out_last, out_data} !== 9'h010) begin failures++; $display("FAIL bp_head: got %h expected 010", {out_last, out_data}); end
    checks++; if (held_bad != 0) begin failures++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", held_bad); end
    out_ready = 1'b1;
    wait_obs(8, 30, to);
    checks++; if (to) begin failures++; $display("FAIL bp_timeout: got %0d words expected 8", obs_q.size()); end
    if (!to) begin
      for (int i = 0; i < 8; i++) begin
        checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_word%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
      end
    end
    checks++; if (pkt_count !== 16'd3) begin failures++; $display("FAIL bp_pkt: got %0d expected 3", pkt_count); end
  endtask

  task automatic test_streaming();
    bit to;
    int bad = 0;
    logic [W-1:0] exp_q[$];
    for (int i = 0; i < 64; i++) exp_q.push_back((i == 63) ? 9'h13F : 9'(i));
    clear_mon();
    out_ready = 1'b1;
    foreach (exp_q[i]) fifo_q.push_back(exp_q[i]);
    wait_obs(64, 100, to);
    checks++; if (to) begin failures++; $display("FAIL stream_timeout: got %0d words expected 64", obs_q.size()); end
    if (!to) begin
      for (int i = 0; i < 64; i++) if (obs_q[i] !== exp_q[i]) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL stream_order: got %0d wrong words expected 0", bad); end
      checks++; if (hs_cyc_q[63] - first_rden + 1 != 66) begin failures++; $display("FAIL stream_cycles: got %0d expected 66", hs_cyc_q[63] - first_rden + 1); end
    end
    checks++; if (pkt_count !== 16'd4) begin failures++; $display("FAIL stream_pkt: got %0d expected 4", pkt_count); end
  endtask

  task automatic test_underflow();
    bit to;
    logic [W-1:0] exp_q[$];
    exp_q = '{9'h020, 9'h021, 9'h122};
    clear_mon();
    out_ready = 1'b1;
    drop_next = 1'b1;
    foreach (exp_q[i]) fifo_q.push_back(exp_q[i]);
    wait_obs(3, 20, to);
    repeat (3) tick();
    checks++; if (obs_q.size() != 3) begin failures++; $display("FAIL uf_count: got %0d words expected 3", obs_q.size()); end
    if (!to) begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL uf_word%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
      end
    end
    checks++; if (err_underflow !== 1'b1) begin failures++; $display("FAIL uf_flag: got %b expected 1", err_underflow); end
    checks++; if (err_spurious !== 1'b0) begin failures++; $display("FAIL uf_spurious: got %b expected 0", err_spurious); end
    checks++; if (rden_cnt != 4) begin failures++; $display("FAIL uf_rden: got %0d expected 4", rden_cnt); end
    checks++; if (pkt_count !== 16'd5) begin failures++; $display("FAIL uf_pkt: got %0d expected 5", pkt_count); end
  endtask

  task automatic test_spurious();
    clear_mon();
    spur_next = 1'b1;
    repeat (3) tick();
    checks++; if (err_spurious !== 1'b1) begin failures++; $display("FAIL spur_flag: got %b expected 1", err_spurious); end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL spur_words: got %0d expected 0", obs_q.size()); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL spur_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid_packet();
    bit to;
    clear_mon();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) fifo_q.push_back(9'(8'h30 + i));
    wait_occ(3, 20, to);
    checks++; if (to) begin failures++; $display("FAIL rmp_occ_timeout: got %0d expected 3", dut.occ); end
    reset_n   = 1'b0;
    spur_next = 1'b1;
    fifo_q.delete();
    #1;
    checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL rmp_rden_in_reset: got %b expected 0", fifo_rd_en); end
    tick();
    reset_n = 1'b1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmp_valid: got %b expected 0", out_valid); end
    checks++; if (pkt_count !== 16'd0) begin failures++; $display("FAIL rmp_pkt: got %0d expected 0", pkt_count); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL rmp_idle: got %b expected 1", idle); end
    checks++; if ({err_underflow, err_spurious} !== 2'b00) begin failures++; $display("FAIL rmp_err: got %b expected 00", {err_underflow, err_spurious}); end
    repeat (2) tick();
    checks++; if (err_spurious !== 1'b0) begin failures++; $display("FAIL rmp_post_spur: got %b expected 0", err_spurious); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmp_post_valid: got %b expected 0", out_valid); end
    out_ready = 1'b1;
  endtask

  task automatic test_rd_rst_busy();
    bit to;
    logic [W-1:0] exp_q[$];
    exp_q = '{9'h050, 9'h051, 9'h052, 9'h053, 9'h054, 9'h155};
    clear_mon();
    out_ready = 1'b0;
    foreach (exp_q[i]) fifo_q.push_back(exp_q[i]);
    wait_occ(2, 20, to);
    checks++; if (to) begin failures++; $display("FAIL busy_occ_timeout: got %0d expected 2", dut.occ); end
    fifo_rd_rst_busy = 1'b1;
    rden_cnt = 0;
    repeat (2) tick();
    out_ready = 1'b1;
    repeat (8) tick();
    checks++; if (fifo_empty !== 1'b0) begin failures++; $display("FAIL busy_fifo_empty: got %b expected 0", fifo_empty); end
    checks++; if (rden_cnt != 0) begin failures++; $display("FAIL busy_rden: got %0d expected 0", rden_cnt); end
    checks++; if (obs_q.size() != 3) begin failures++; $display("FAIL busy_drain_count: got %0d expected 3", obs_q.size()); end
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL busy_word%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL busy_idle: got %b expected 1", idle); end
    fifo_rd_rst_busy = 1'b0;
    wait_obs(6, 20, to);
    checks++; if (to) begin failures++; $display("FAIL busy_resume_timeout: got %0d words expected 6", obs_q.size()); end
    if (!to) begin
      for (int i = 3; i < 6; i++) begin
        checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL busy_resume%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
      end
    end
    checks++; if (pkt_count !== 16'd1) begin failures++; $display("FAIL busy_pkt: got %0d expected 1", pkt_count); end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin : main
    test_reset();
    test_single_packet();
    test_backpressure();
    test_streaming();
    test_underflow();
    test_spurious();
    test_reset_mid_packet();
    test_rd_rst_busy();
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
